div_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative nonrestoring divider among several requesters in the RSA decryption datapath, such as the n0prime and q-inverse extended-Euclid units. It accepts divide requests, grants one requester at a time, and latches that requester's operands. It then pulses the divider start, waits for divider done, and returns quotient and remainder to the granted requester with a one-cycle acknowledge.

---
 rtl/rsa_div_pkg.sv | 19 +
 rtl/rr_pick.sv | 32 +++
 rtl/div_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_div_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_div_pkg.sv
// Shared types and constants for the RSA datapath divider-sharing arbiter.
package rsa_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;
  localparam int MAX_W       = 64;

  // Quotient reported for a zero divisor; sliced down to the operand width.
  localparam logic [MAX_W-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester above ptr, wrapping.
module rr_pick
  import rsa_div_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int cand;

  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        winner[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider among NREQ requesters with round-robin grants.
// Optional WAIT watchdog is enabled by defining DIV_TIMEOUT_EN.
module div_share_arbiter
  import rsa_div_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dividend,
  input  logic [NREQ*W-1:0] divisor,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      quo,
  output logic [W-1:0]      rem,
  output logic              err,
  output logic              div_start,
  output logic [W-1:0]      div_q,
  output logic [W-1:0]      div_m,
  output logic [W-1:0]      div_a,
  input  logic [W-1:0]      div_q_out,
  input  logic [W-1:0]      div_r,
  input  logic              div_done
);

  localparam int IW = $clog2(NREQ);

  div_state_t      state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            pick_valid;
  logic [W-1:0]    sel_dividend;
  logic [W-1:0]    sel_divisor;
  logic            div0;
  logic            grant;
  logic            capture;
  logic            expire;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign sel_dividend = dividend[pick_idx*W +: W];
  assign sel_divisor  = divisor[pick_idx*W +: W];
  assign div_a        = '0;

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (grant)
      tmo_cnt <= '0;
    else if (state == WAIT)
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A zero divisor still spends its START cycle (without the pulse) so the
  // ack lands one cycle after grant rather than on the grant edge itself.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant     = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = div0 ? RESP : WAIT;
      WAIT: begin
        if (div_done) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
`ifdef DIV_TIMEOUT_EN
        else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      ack       <= '0;
      quo       <= '0;
      rem       <= '0;
      err       <= 1'b0;
      div_start <= 1'b0;
      div_q     <= '0;
      div_m     <= '0;
      div0      <= 1'b0;
      ptr       <= IW'(NREQ - 1);
    end else begin
      div_start <= 1'b0;
      ack       <= (state_nxt == RESP && state != RESP) ? gnt : '0;
      if (grant) begin
        gnt       <= pick_oh;
        ptr       <= pick_idx;
        div_q     <= sel_dividend;
        div_m     <= sel_divisor;
        div0      <= (sel_divisor == '0);
        div_start <= (sel_divisor != '0);
      end
      if (state == START && div0) begin
        quo <= DIV0_QUO[W-1:0];
        rem <= div_q;
        err <= 1'b1;
      end
      if (capture) begin
        quo <= div_q_out;
        rem <= div_r;
        err <= 1'b0;
      end
      if (expire) begin
        quo <= '0;
        rem <= '0;
        err <= 1'b1;
      end
      if (state == RESP)
        gnt <= '0;
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter with a behavioural divider model.
module tb_div_share_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] dividend;
  logic [NREQ*W-1:0] divisor;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      quo;
  logic [W-1:0]      rem;
  logic              err;
  logic              div_start;
  logic [W-1:0]      div_q;
  logic [W-1:0]      div_m;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_q_out;
  logic [W-1:0]      div_r;
  logic              div_done;

  logic              modelDone;
  logic              strayDone;
  bit                hang;
  int                lat;
  int                modelCnt;
  logic [W-1:0]      mq, mm;
  int                startCount;
  int                checks;
  int                failures;
  int                refPtr;

  assign div_done = modelDone | strayDone;

  div_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dividend  (dividend),
    .divisor   (divisor),
    .gnt       (gnt),
    .ack       (ack),
    .quo       (quo),
    .rem       (rem),
    .err       (err),
    .div_start (div_start),
    .div_q     (div_q),
    .div_m     (div_m),
    .div_a     (div_a),
    .div_q_out (div_q_out),
    .div_r     (div_r),
    .div_done  (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: lat cycles after seeing the start pulse it raises done for one cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelCnt  = 0;
      modelDone = 1'b0;
      div_q_out = '0;
      div_r     = '0;
    end else begin
      modelDone = 1'b0;
      div_q_out = W'($urandom);
      div_r     = W'($urandom);
      if (div_start) begin
        modelCnt = lat;
        mq = div_q;
        mm = div_m;
      end else if (modelCnt > 0) begin
        modelCnt--;
        if (modelCnt == 0 && !hang) begin
          modelDone = 1'b1;
          div_q_out = mq / mm;
          div_r     = mq % mm;
        end
      end
    end
  end

  always @(posedge clk) if (div_start) startCount++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend[r*W +: W] = a;
    divisor[r*W +: W]  = b;
    req[r]             = 1'b1;
  endtask

  function automatic int nextWinner(input logic [NREQ-1:0] pend, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) tick();
    rst_n  = 1'b1;
    refPtr = NREQ - 1;
  endtask

  // Waits for the grant, checks latched operands, waits for ack, checks the result.
  task automatic runTransfer(input string tag, input int w, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit scramble);
    int n;
    int s0;
    logic [W-1:0] eq, er;
    logic ee;
    int elat;
    if (hang) begin
      eq = '0; er = '0; ee = 1'b1; elat = TIMEOUT + 1;
    end else if (b == 0) begin
      eq = '1; er = a; ee = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; ee = 1'b0; elat = lat + 1;
    end
    n = 0;
    while (gnt == '0 && n < 20) begin tick(); n++; end
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(1 << w));
    checkOutput({tag, ".div_q"}, 32'(div_q), 32'(a));
    checkOutput({tag, ".div_m"}, 32'(div_m), 32'(b));
    checkOutput({tag, ".div_start"}, 32'(div_start), 32'(b != 0));
    s0 = startCount;
    if (scramble) dividend[w*W +: W] = ~a;
    n = 0;
    while (ack == '0 && n < TIMEOUT + 60) begin tick(); n++; end
    checkOutput({tag, ".ack"}, 32'(ack), 32'(1 << w));
    checkOutput({tag, ".latency"}, 32'(n), 32'(elat));
    checkOutput({tag, ".gnt_held"}, 32'(gnt), 32'(1 << w));
    checkOutput({tag, ".quo"}, 32'(quo), 32'(eq));
    checkOutput({tag, ".rem"}, 32'(rem), 32'(er));
    checkOutput({tag, ".err"}, 32'(err), 32'(ee));
    checkOutput({tag, ".starts"}, 32'(startCount - s0), 32'(b != 0));
    req[w] = 1'b0;
    refPtr = w;
    tick();
    checkOutput({tag, ".ack_pulse"}, 32'(ack), 32'(0));
    checkOutput({tag, ".gnt_clear"}, 32'(gnt), 32'(0));
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] pend;
    logic [W-1:0] opA [NREQ];
    logic [W-1:0] opB [NREQ];
    checks = 0; failures = 0; startCount = 0;
    rst_n = 1'b0; req = '0; dividend = '0; divisor = '0;
    strayDone = 1'b0; hang = 1'b0; lat = 10; refPtr = NREQ - 1;
    repeat (2) tick();
    checkOutput("rst.gnt", 32'(gnt), 0);
    checkOutput("rst.ack", 32'(ack), 0);
    checkOutput("rst.quo", 32'(quo), 0);
    checkOutput("rst.rem", 32'(rem), 0);
    checkOutput("rst.err", 32'(err), 0);
    checkOutput("rst.div_start", 32'(div_start), 0);
    checkOutput("rst.div_q", 32'(div_q), 0);
    checkOutput("rst.div_m", 32'(div_m), 0);
    checkOutput("rst.div_a", 32'(div_a), 0);
    rst_n = 1'b1;
    tick();

    // Single request 100/7 with a 10-cycle divider.
    lat = 10;
    applyStimulus(1, 8'd100, 8'd7);
    runTransfer("single", 1, 8'd100, 8'd7, 1'b0);

    // Contention from a fresh reset: 0 then 2, then 3 then 0.
    doReset();
    lat = 4;
    applyStimulus(0, 8'd77, 8'd5);
    applyStimulus(2, 8'd250, 8'd16);
    runTransfer("cont_a0", 0, 8'd77, 8'd5, 1'b0);
    runTransfer("cont_a2", 2, 8'd250, 8'd16, 1'b0);
    applyStimulus(0, 8'd13, 8'd13);
    applyStimulus(3, 8'd0, 8'd9);
    runTransfer("cont_b3", 3, 8'd0, 8'd9, 1'b0);
    runTransfer("cont_b0", 0, 8'd13, 8'd13, 1'b0);

    // Divide by zero.
    applyStimulus(3, 8'd55, 8'd0);
    runTransfer("div0", 3, 8'd55, 8'd0, 1'b0);

    // Reset while the divider is busy.
    lat = 30;
    applyStimulus(0, 8'd200, 8'd3);
    n = 0;
    while (gnt == '0 && n < 20) begin tick(); n++; end
    checkOutput("rstwait.gnt", 32'(gnt), 32'h1);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwait.gnt0", 32'(gnt), 0);
    checkOutput("rstwait.ack0", 32'(ack), 0);
    checkOutput("rstwait.quo0", 32'(quo), 0);
    checkOutput("rstwait.rem0", 32'(rem), 0);
    checkOutput("rstwait.err0", 32'(err), 0);
    checkOutput("rstwait.div_q0", 32'(div_q), 0);
    checkOutput("rstwait.div_m0", 32'(div_m), 0);
    req = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    refPtr = NREQ - 1;
    tick();
    checkOutput("rstwait.no_ack", 32'(ack), 0);
    lat = 5;
    applyStimulus(0, 8'd9, 8'd4);
    runTransfer("post_rst", 0, 8'd9, 8'd4, 1'b0);

    // Stray done in IDLE, then an operand change after grant.
    strayDone = 1'b1;
    tick();
    strayDone = 1'b0;
    checkOutput("stray.gnt", 32'(gnt), 0);
    checkOutput("stray.ack", 32'(ack), 0);
    checkOutput("stray.div_start", 32'(div_start), 0);
    lat = 3;
    applyStimulus(2, 8'd123, 8'd10);
    runTransfer("opchg", 2, 8'd123, 8'd10, 1'b1);

    // Randomized bursts of simultaneous requests.
    for (int round = 0; round < 6; round++) begin
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        opA[i] = W'($urandom_range(0, 255));
        opB[i] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
        if (pend[i]) applyStimulus(i, opA[i], opB[i]);
      end
      while (pend != '0) begin
        int w;
        w   = nextWinner(pend, refPtr);
        lat = $urandom_range(1, 12);
        runTransfer($sformatf("rand%0d_r%0d", round, w), w, opA[w], opB[w], 1'b0);
        pend[w] = 1'b0;
      end
    end

`ifdef DIV_TIMEOUT_EN
    // Divider that never answers.
    hang = 1'b1;
    lat  = 2;
    applyStimulus(1, 8'd10, 8'd3);
    runTransfer("timeout", 1, 8'd10, 8'd3, 1'b0);
    hang = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
